// File: rtl/exec_wb_if.sv
// exec_wb_if: execute-result, memory-writeback, register-file and forwarding signals of the writeback arbiter
interface exec_wb_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_result;
  logic [4:0]        ex_dst;
  logic              ex_overflow;
  logic              ex_ready;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_data;
  logic [4:0]        mem_dst;
  logic              flush;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              ovf_exc;
  logic [4:0]        fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CW-1:0]     count;
  modport master (
    output ex_valid, ex_result, ex_dst, ex_overflow, mem_valid, mem_data, mem_dst, flush, fwd_addr,
    input  ex_ready, rf_we, rf_waddr, rf_wdata, ovf_exc, fwd_hit, fwd_data, count
  );
  modport slave (
    input  ex_valid, ex_result, ex_dst, ex_overflow, mem_valid, mem_data, mem_dst, flush, fwd_addr,
    output ex_ready, rf_we, rf_waddr, rf_wdata, ovf_exc, fwd_hit, fwd_data, count
  );
endinterface

// File: rtl/exec_wb_arbiter.sv
// exec_wb_arbiter: shares the register-file write port between memory loads (priority) and execute
// results, buffering losing execute results in order and exposing them to forwarding.
module exec_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input logic   clk,
  input logic   rst,
  exec_wb_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [4:0]        dst_q  [DEPTH];
  logic [PW-1:0]     head, tail, idx;
  logic [CW-1:0]     cnt;
  logic              ready, acc, good, ovf, pop, bypass, push;
  logic              we_n, hit;
  logic [4:0]        waddr_n;
  logic [DATA_W-1:0] wdata_n, fdata;
  assign ready = cnt < FULL;
  assign bus.ex_ready = ready;
  assign bus.count    = cnt;
  assign bus.fwd_hit  = hit;
  assign bus.fwd_data = fdata;
  // Flush suppresses the pop so buffered results are discarded rather than written.
  always_comb begin
    acc     = bus.ex_valid & ready & ~bus.flush;
    good    = acc & ~bus.ex_overflow & (bus.ex_dst != 5'd0);
    ovf     = acc & bus.ex_overflow;
    pop     = ~bus.mem_valid & (cnt != '0) & ~bus.flush;
    bypass  = ~bus.mem_valid & (cnt == '0) & good;
    push    = good & ~bypass;
    we_n    = bus.mem_valid ? (bus.mem_dst != 5'd0) : (pop | bypass);
    waddr_n = bus.mem_valid ? bus.mem_dst : pop ? dst_q[head] : bus.ex_dst;
    wdata_n = bus.mem_valid ? bus.mem_data : pop ? data_q[head] : bus.ex_result;
  end
  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    hit   = 1'b0;
    fdata = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < cnt && dst_q[idx] == bus.fwd_addr && bus.fwd_addr != 5'd0) begin
        hit   = 1'b1;
        fdata = data_q[idx];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.ovf_exc  <= 1'b0;
    end else begin
      bus.rf_we    <= we_n;
      bus.rf_waddr <= waddr_n;
      bus.rf_wdata <= wdata_n;
      bus.ovf_exc  <= ovf;
      if (bus.flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        head <= pop ? head + 1'b1 : head;
        tail <= push ? tail + 1'b1 : tail;
        cnt  <= cnt + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail] <= bus.ex_result;
      dst_q[tail]  <= bus.ex_dst;
    end
  end
endmodule

// File: tb/tb_exec_wb_arbiter.sv
// tb_exec_wb_arbiter: table-driven vectors plus hand-written stall, flush and reset sequences.
module tb_exec_wb_arbiter;
  localparam int DW = 32;
  localparam int D  = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  exec_wb_if #(.DATA_W(DW), .DEPTH(D)) bus ();
  exec_wb_arbiter #(.DATA_W(DW), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic ex_v; logic [31:0] ex_r; logic [4:0] ex_d; logic ex_o;
    logic m_v; logic [31:0] m_d; logic [4:0] m_a; logic fl; logic [4:0] fa;
    logic we; logic [4:0] wa; logic [31:0] wd; logic ovf; logic [1:0] cnt;
    logic rdy; logic hit; logic [31:0] fd;
  } vec_t;
  vec_t vec [15];
  int n_chk = 0;
  int n_fail = 0;
  logic [4:0]  la [$];
  logic [31:0] ld [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic ex_v, input logic [31:0] ex_r, input logic [4:0] ex_d, input logic ex_o,
                       input logic m_v, input logic [31:0] m_d, input logic [4:0] m_a, input logic fl,
                       input logic [4:0] fa);
    bus.ex_valid = ex_v; bus.ex_result = ex_r; bus.ex_dst = ex_d; bus.ex_overflow = ex_o;
    bus.mem_valid = m_v; bus.mem_data = m_d; bus.mem_dst = m_a; bus.flush = fl; bus.fwd_addr = fa;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    #1;
    if (bus.rf_we === 1'b1) begin
      la.push_back(bus.rf_waddr);
      ld.push_back(bus.rf_wdata);
    end
  end
  initial begin
    int j, m, nm, bad, max_c;
    logic rdy, saw_stall;
    vec[0]  = '{1, 'hAA,   5, 0, 0, 0,     0, 0, 0,  1, 5, 'hAA,   0, 0, 1, 0, 0};
    vec[1]  = '{1, 'h2222, 4, 0, 1, 'h1111, 3, 0, 4, 1, 3, 'h1111, 0, 1, 1, 1, 'h2222};
    vec[2]  = '{0, 0,      0, 0, 0, 0,     0, 0, 4,  1, 4, 'h2222, 0, 0, 1, 0, 0};
    vec[3]  = '{1, 'h1234, 7, 1, 0, 0,     0, 0, 7,  0, 0, 0,      1, 0, 1, 0, 0};
    vec[4]  = '{0, 0,      0, 0, 0, 0,     0, 0, 7,  0, 0, 0,      0, 0, 1, 0, 0};
    vec[5]  = '{1, 'h55,   0, 0, 0, 0,     0, 0, 0,  0, 0, 0,      0, 0, 1, 0, 0};
    vec[6]  = '{1, 'h22,   2, 0, 1, 'h77,  0, 0, 2,  0, 0, 0,      0, 1, 1, 1, 'h22};
    vec[7]  = '{0, 0,      0, 0, 0, 0,     0, 0, 2,  1, 2, 'h22,   0, 0, 1, 0, 0};
    vec[8]  = '{1, 5,      8, 0, 1, 'h100, 1, 0, 8,  1, 1, 'h100,  0, 1, 1, 1, 5};
    vec[9]  = '{1, 9,      8, 0, 1, 'h101, 1, 0, 8,  1, 1, 'h101,  0, 2, 0, 1, 9};
    vec[10] = '{0, 0,      0, 0, 1, 'h102, 1, 0, 8,  1, 1, 'h102,  0, 2, 0, 1, 9};
    vec[11] = '{0, 0,      0, 0, 0, 0,     0, 0, 8,  1, 8, 5,      0, 1, 1, 1, 9};
    vec[12] = '{0, 0,      0, 0, 0, 0,     0, 0, 8,  1, 8, 9,      0, 0, 1, 0, 0};
    vec[13] = '{1, 'hBAD,  3, 1, 1, 'h66,  6, 0, 0,  1, 6, 'h66,   1, 0, 1, 0, 0};
    vec[14] = '{1, 'h99,   9, 0, 0, 0,     0, 1, 9,  0, 0, 0,      0, 0, 1, 0, 0};
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst rf_we", bus.rf_we, 0);
    chk("rst rf_waddr", bus.rf_waddr, 0);
    chk("rst rf_wdata", bus.rf_wdata, 0);
    chk("rst ovf_exc", bus.ovf_exc, 0);
    chk("rst count", bus.count, 0);
    chk("rst ex_ready", bus.ex_ready, 1);
    chk("rst fwd_hit", bus.fwd_hit, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vec[i].ex_v, vec[i].ex_r, vec[i].ex_d, vec[i].ex_o, vec[i].m_v, vec[i].m_d, vec[i].m_a,
            vec[i].fl, vec[i].fa);
      step();
      chk($sformatf("v%0d rf_we", i), bus.rf_we, vec[i].we);
      if (vec[i].we) begin
        chk($sformatf("v%0d rf_waddr", i), bus.rf_waddr, vec[i].wa);
        chk($sformatf("v%0d rf_wdata", i), bus.rf_wdata, vec[i].wd);
      end
      chk($sformatf("v%0d ovf_exc", i), bus.ovf_exc, vec[i].ovf);
      chk($sformatf("v%0d count", i), bus.count, vec[i].cnt);
      chk($sformatf("v%0d ex_ready", i), bus.ex_ready, vec[i].rdy);
      chk($sformatf("v%0d fwd_hit", i), bus.fwd_hit, vec[i].hit);
      chk($sformatf("v%0d fwd_data", i), bus.fwd_data, vec[i].fd);
    end
    // Memory held four cycles while r1..r3 issue back-to-back.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    la.delete();
    ld.delete();
    j = 0; max_c = 0; saw_stall = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rdy = bus.ex_ready;
      if (!rdy && j < 3) saw_stall = 1;
      drive(j < 3, 32'(j + 1), 5'(j + 1), 0, c < 4, 32'(c + 16), 5'd20, 0, 0);
      step();
      if (rdy && j < 3) j++;
      if (int'(bus.count) > max_c) max_c = int'(bus.count);
    end
    chk("stall accepted", j, 3);
    chk("stall max count", max_c, 2);
    chk("stall ex_ready low", saw_stall, 1);
    chk("stall drained", bus.count, 0);
    m = 0; nm = 0;
    foreach (la[k]) begin
      if (la[k] == 5'd20) nm++;
      else begin
        chk($sformatf("stall order addr %0d", m), la[k], m + 1);
        chk($sformatf("stall order data %0d", m), ld[k], m + 1);
        m++;
      end
    end
    chk("stall ex writes", m, 3);
    chk("stall mem writes", nm, 4);
    // Flush with two buffered entries and a concurrent memory write.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    la.delete();
    ld.delete();
    @(negedge clk);
    drive(1, 'h1, 1, 0, 1, 'hA, 20, 0, 0);
    step();
    @(negedge clk);
    drive(1, 'h2, 2, 0, 1, 'hB, 20, 0, 0);
    step();
    chk("flush pre count", bus.count, 2);
    chk("flush pre ex_ready", bus.ex_ready, 0);
    @(negedge clk);
    drive(1, 'h9, 9, 0, 1, 'h66, 6, 1, 0);
    step();
    chk("flush count", bus.count, 0);
    chk("flush mem rf_we", bus.rf_we, 1);
    chk("flush mem rf_waddr", bus.rf_waddr, 6);
    chk("flush mem rf_wdata", bus.rf_wdata, 'h66);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    bad = 0;
    foreach (la[k]) if (la[k] == 5'd1 || la[k] == 5'd2 || la[k] == 5'd9) bad++;
    chk("flush discarded writes", bad, 0);
    chk("flush write total", la.size(), 3);
    chk("flush post ex_ready", bus.ex_ready, 1);
    // Reset asserted mid-stall.
    @(negedge clk);
    drive(1, 'h11, 11, 0, 1, 'hC, 20, 0, 11);
    step();
    @(negedge clk);
    drive(1, 'h12, 12, 0, 1, 'hD, 20, 0, 11);
    step();
    chk("midrst pre count", bus.count, 2);
    chk("midrst pre fwd_hit", bus.fwd_hit, 1);
    chk("midrst pre rf_we", bus.rf_we, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst rf_we", bus.rf_we, 0);
    chk("midrst rf_waddr", bus.rf_waddr, 0);
    chk("midrst rf_wdata", bus.rf_wdata, 0);
    chk("midrst ovf_exc", bus.ovf_exc, 0);
    chk("midrst count", bus.count, 0);
    chk("midrst ex_ready", bus.ex_ready, 1);
    chk("midrst fwd_hit", bus.fwd_hit, 0);
    chk("midrst fwd_data", bus.fwd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_wb_arbiter.md
# exec_wb_arbiter

Consumer end of the execute-stage result interface. Accepts the final execute result (result, destination register, overflow flag) and owns the single register-file write port, sharing it with memory-stage load returns. Memory writes have priority; execute results that lose arbitration are held in a small in-order buffer with back-pressure to execute. Buffered values are also exposed to the forwarding unit.

## Interface
- `DATA_W`, 32, width of result and register-file data
- `DEPTH`, 2, execute-result buffer entries (power of two, ≥2)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ex_valid`  in  1  execute result present this cycle
- `ex_result`  in  DATA_W  execute result
- `ex_dst`  in  5  destination register
- `ex_overflow`  in  1  arithmetic overflow on this result
- `ex_ready`  out  1  block can accept an execute result this cycle
- `mem_valid`  in  1  memory-stage writeback present (always accepted)
- `mem_data`  in  DATA_W  load data
- `mem_dst`  in  5  load destination register
- `flush`  in  1  discard all pending execute results
- `rf_we`  out  1  register-file write enable (registered)
- `rf_waddr`  out  5  write address (registered)
- `rf_wdata`  out  DATA_W  write data (registered)
- `ovf_exc`  out  1  one-cycle overflow exception pulse (registered)
- `fwd_addr`  in  5  forwarding lookup register
- `fwd_hit`  out  1  lookup matches a buffered entry
- `fwd_data`  out  DATA_W  data of youngest matching entry
- `count`  out  $clog2(DEPTH)+1  buffered entries

## Operation
- Accept: `ex_valid & ex_ready & ~flush`. `ex_ready = (count < DEPTH)`, from registered count only; no push into a full buffer even when a pop happens that cycle.
- Filter at accept: `ex_overflow=1` → not written, not buffered, `ovf_exc=1` next cycle. `ex_dst=0` (no overflow) → accepted and discarded.
- Write-port selection, priority order each cycle:
  1. `mem_valid` → write mem_dst/mem_data (mem_dst=0 → `rf_we` stays 0, port still consumed).
  2. Buffer non-empty → pop oldest entry and write it.
  3. Buffer empty and an accepted, filtered execute result → bypass, write it directly.
  4. Else `rf_we=0`.
- Accepted result not written this cycle is pushed at the tail. In-order guarantee applies among execute results only; ordering against memory writes to the same register belongs to the hazard unit.
- Simultaneous push and pop: both happen, count unchanged.
- Flush: buffer cleared next edge; same-cycle execute input dropped; memory write proceeds; an `rf_*` write already registered is not cancelled.
- Forwarding (combinational): `fwd_hit=1` if any valid buffered entry has dst==`fwd_addr`, `fwd_data` = youngest match. `fwd_addr=0` → `fwd_hit=0`. Entries leave the lookup on the edge they are popped. `fwd_data=0` when no hit.
- Buffer: circular, head/tail pointers wrap modulo DEPTH.

## Timing
- Reset (async, immediate): `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `ovf_exc=0`, `count=0`, buffer invalid, pointers 0 → `ex_ready=1`, `fwd_hit=0`.
- Latency: bypassed result → `rf_we` the cycle after acceptance. Memory write → next cycle, always.
- Buffered entry: written ≥1 cycle after the first cycle with `mem_valid=0` and no older entry.
- `ovf_exc`: exactly one cycle, the cycle after the accept; it is not suppressed by a simultaneous `mem_valid`.
- `ex_ready` deasserts the cycle after count reaches DEPTH and reasserts the cycle after the first pop.

## Test plan
- Reset, then ex r5=0x0000_00AA with no mem → next cycle rf_we=1, waddr=5, wdata=0xAA; count stays 0.
- mem r3=0x1111 and ex r4=0x2222 in the same cycle → cycle+1 writes r3; cycle+2 writes r4; fwd_addr=4 during cycle+1 → fwd_hit=1, fwd_data=0x2222.
- mem_valid held 4 cycles while ex issues r1=1, r2=2, r3=3 back-to-back → count reaches 2, ex_ready=0 and r3 stalls; after mem drops, writes r1, r2, r3 in order; no loss or duplication.
- ex r7 overflow=1 → ovf_exc pulses one cycle, rf_we stays 0, count 0; ex dst=0 → no write.
- Two entries buffered (r1, r2) plus flush with ex r9 → count=0 next edge, r1/r2/r9 never written, concurrent mem r6 still written.
- Buffered r8=0x5 then r8=0x9 → fwd_addr=8 gives 0x9; assert rst mid-stall → all outputs at reset values immediately, ex_ready=1.
